// File: rtl/alu_arb_if.sv
// rtl/alu_arb_if.sv - request/response/alu signal bundle for alu_arb
//
// Purpose: groups the two requester ports, the two response ports, the alu
//   drive/return signals and the busy flag shared by alu_arb and its neighbours.
// Ports (signals):
//   reqN_valid/ready/op/left/right  requester N op handshake (N = 0, 1)
//   rspN_valid/ready/data/cond      result handshake back to requester N
//   alu_op/left/right               registered operands to the alu
//   alu_out/alu_cond                combinational alu result
//   busy                            arbiter not idle
// Modports: slave = alu_arb side, master = surrounding datapath / bench side.
interface alu_arb_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) ();
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_left;
  logic [DATA_W-1:0] req0_right;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_left;
  logic [DATA_W-1:0] req1_right;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_cond;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_cond;

  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_left;
  logic [DATA_W-1:0] alu_right;
  logic [DATA_W-1:0] alu_out;
  logic              alu_cond;

  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_left, req0_right,
    input  req1_valid, req1_op, req1_left, req1_right,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_cond,
    output rsp1_valid, rsp1_data, rsp1_cond,
    input  rsp0_ready, rsp1_ready,
    output alu_op, alu_left, alu_right,
    input  alu_out, alu_cond,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_left, req0_right,
    output req1_valid, req1_op, req1_left, req1_right,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_cond,
    input  rsp1_valid, rsp1_data, rsp1_cond,
    output rsp0_ready, rsp1_ready,
    input  alu_op, alu_left, alu_right,
    output alu_out, alu_cond,
    input  busy
  );
endinterface

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - round-robin sharing of one combinational alu between two requesters
//
// Purpose: accepts one op at a time from port 0 or port 1 (round-robin when both
//   request), registers the operands into the alu, captures the alu result one
//   cycle later and holds it for the owning port until that port accepts it.
//   Ops are never decoded here.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    alu_arb_if.slave: reqN_* op handshakes, rspN_* result handshakes,
//          alu_op/left/right to the alu, alu_out/alu_cond from it, busy
module alu_arb #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 5
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              prio;
  logic              owner;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] left_q;
  logic [DATA_W-1:0] right_q;
  logic [DATA_W-1:0] data_q;
  logic              cond_q;

  logic any_req;
  logic grant;
  logic accept;
  logic owner_ready;

  // A lone requester always wins; prio only breaks ties.
  assign any_req     = bus.req0_valid | bus.req1_valid;
  assign grant       = (bus.req0_valid & bus.req1_valid) ? prio : bus.req1_valid;
  assign accept      = (state == IDLE) & any_req;
  assign owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (owner_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers: operands on accept, result one cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio    <= 1'b0;
      owner   <= 1'b0;
      op_q    <= '0;
      left_q  <= '0;
      right_q <= '0;
      data_q  <= '0;
      cond_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= grant ? bus.req1_op    : bus.req0_op;
        left_q  <= grant ? bus.req1_left  : bus.req0_left;
        right_q <= grant ? bus.req1_right : bus.req0_right;
        owner   <= grant;
        prio    <= ~grant;
      end
      if (state == EXEC) begin
        data_q <= bus.alu_out;
        cond_q <= bus.alu_cond;
      end
    end
  end

  // Output logic. Ready is gated by rst_n so that an asserted reset forces it
  // low at once even while requesters keep valid high.
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.rsp0_valid = 1'b0;
    bus.rsp1_valid = 1'b0;
    if (rst_n && accept) begin
      bus.req0_ready = ~grant;
      bus.req1_ready = grant;
    end
    if (state == RESP) begin
      bus.rsp0_valid = ~owner;
      bus.rsp1_valid = owner;
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.alu_op    = op_q;
  assign bus.alu_left  = left_q;
  assign bus.alu_right = right_q;
  assign bus.rsp0_data = data_q;
  assign bus.rsp0_cond = cond_q;
  assign bus.rsp1_data = data_q;
  assign bus.rsp1_cond = cond_q;

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - self-checking bench for alu_arb
module tb_alu_arb;
  localparam int DATA_W = 32;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_EQ   = 5'd2;
  localparam logic [OP_W-1:0] OP_LT   = 5'd3;
  localparam logic [OP_W-1:0] OP_URSH = 5'd4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_arb_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  alu_arb #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Reference alu: unsigned compare/shift, cond = result bit 0
  logic [DATA_W-1:0] alu_res;
  always_comb begin
    case (bus.alu_op)
      OP_ADD:  alu_res = bus.alu_left + bus.alu_right;
      OP_SUB:  alu_res = bus.alu_left - bus.alu_right;
      OP_EQ:   alu_res = {{(DATA_W-1){1'b0}}, bus.alu_left == bus.alu_right};
      OP_LT:   alu_res = {{(DATA_W-1){1'b0}}, bus.alu_left < bus.alu_right};
      OP_URSH: alu_res = bus.alu_left >> bus.alu_right[4:0];
      default: alu_res = '0;
    endcase
  end
  assign bus.alu_out  = alu_res;
  assign bus.alu_cond = alu_res[0];

  typedef struct {
    logic              port;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] l;
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] data;
    logic              cond;
  } vec_t;

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] data;
    logic              cond;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic p, input logic [DATA_W-1:0] d, input logic c);
    exp_t e;
    e.port = p;
    e.data = d;
    e.cond = c;
    sb.push_back(e);
  endtask

  task automatic pop(input logic p, input logic [DATA_W-1:0] d, input logic c);
    exp_t e;
    if (sb.size() == 0) begin
      check("rsp_unexpected", {63'd0, p}, 64'hDEAD);
    end else begin
      e = sb.pop_front();
      check("rsp_port", {63'd0, p}, {63'd0, e.port});
      check("rsp_data", {32'd0, d}, {32'd0, e.data});
      check("rsp_cond", {63'd0, c}, {63'd0, e.cond});
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake
  always @(negedge clk) begin
    #2;
    if (bus.rsp0_valid && bus.rsp1_valid) check("rsp_both_valid", 64'd1, 64'd0);
    if (bus.rsp0_valid && bus.rsp0_ready) pop(1'b0, bus.rsp0_data, bus.rsp0_cond);
    if (bus.rsp1_valid && bus.rsp1_ready) pop(1'b1, bus.rsp1_data, bus.rsp1_cond);
  end

  function automatic logic rdy(input logic p);
    return p ? bus.req1_ready : bus.req0_ready;
  endfunction

  function automatic logic rvalid(input logic p);
    return p ? bus.rsp1_valid : bus.rsp0_valid;
  endfunction

  task automatic set_req(input logic p, input logic v, input logic [OP_W-1:0] op,
                         input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    if (p) begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_left = l; bus.req1_right = r;
    end else begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_left = l; bus.req0_right = r;
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && bus.busy; i++) begin
      @(negedge clk); #1;
    end
    check("idle_timeout", {63'd0, bus.busy}, 64'd0);
  endtask

  // Single-port op with latency checks: accept at N, EXEC at N+1, rsp_valid at N+2
  task automatic issue(input vec_t v);
    @(negedge clk);
    set_req(v.port, 1'b1, v.op, v.l, v.r);
    #1;
    for (int i = 0; i < 20 && !rdy(v.port); i++) begin
      @(negedge clk); #1;
    end
    check("issue_ready", {63'd0, rdy(v.port)}, 64'd1);
    check("issue_other_ready", {63'd0, rdy(~v.port)}, 64'd0);
    push(v.port, v.data, v.cond);
    @(negedge clk);
    set_req(v.port, 1'b0, v.op, v.l, v.r);
    #1;
    check("exec_rsp_valid", {63'd0, rvalid(v.port)}, 64'd0);
    check("exec_busy", {63'd0, bus.busy}, 64'd1);
    check("exec_ready", {63'd0, rdy(v.port)}, 64'd0);
    @(negedge clk); #1;
    check("lat_rsp_valid", {63'd0, rvalid(v.port)}, 64'd1);
    check("lat_other_valid", {63'd0, rvalid(~v.port)}, 64'd0);
    wait_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] held;
    logic              seen;

    vecs[0] = '{1'b0, OP_ADD,  32'd5,        32'd7,  32'd12,       1'b0};
    vecs[1] = '{1'b1, OP_SUB,  32'd9,        32'd4,  32'd5,        1'b1};
    vecs[2] = '{1'b0, OP_LT,   32'hFFFFFFFF, 32'd1,  32'd0,        1'b0};
    vecs[3] = '{1'b1, OP_URSH, 32'h80000000, 32'd31, 32'd1,        1'b1};
    vecs[4] = '{1'b0, OP_EQ,   32'd3,        32'd4,  32'd0,        1'b0};
    vecs[5] = '{1'b1, OP_ADD,  32'hFFFFFFFF, 32'd1,  32'd0,        1'b0};
    vecs[6] = '{1'b1, OP_SUB,  32'd0,        32'd1,  32'hFFFFFFFF, 1'b1};

    // Both ports valid through reset
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    set_req(1'b0, 1'b1, OP_EQ, 32'd3, 32'd3);
    set_req(1'b1, 1'b1, OP_SUB, 32'd9, 32'd4);
    @(negedge clk); @(negedge clk); #1;
    check("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
    check("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
    check("rst_rsp1_valid", {63'd0, bus.rsp1_valid}, 64'd0);
    check("rst_alu_op", {59'd0, bus.alu_op}, 64'd0);
    check("rst_alu_left", {32'd0, bus.alu_left}, 64'd0);
    check("rst_rsp_data", {32'd0, bus.rsp0_data}, 64'd0);

    // Round-robin with both held valid: grants 0,1,0,1
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 20 && !(bus.req0_ready || bus.req1_ready); i++) begin
        @(negedge clk); #1;
      end
      check("rr_one_ready", {63'd0, bus.req0_ready ^ bus.req1_ready}, 64'd1);
      check("rr_grant", {63'd0, bus.req1_ready}, g % 2);
      if (bus.req1_ready) push(1'b1, 32'd5, 1'b1);
      else                push(1'b0, 32'd1, 1'b1);
      @(negedge clk); #1;
    end
    set_req(1'b0, 1'b0, OP_EQ, 32'd3, 32'd3);
    set_req(1'b1, 1'b0, OP_SUB, 32'd9, 32'd4);
    wait_idle();

    // Backpressure on rsp0 while req1 waits
    bus.rsp0_ready = 1'b0;
    @(negedge clk);
    set_req(1'b0, 1'b1, OP_ADD, 32'd100, 32'd23);
    #1;
    check("bp_ready0", {63'd0, bus.req0_ready}, 64'd1);
    push(1'b0, 32'd123, 1'b1);
    @(negedge clk);
    set_req(1'b0, 1'b0, OP_ADD, 32'd100, 32'd23);
    set_req(1'b1, 1'b1, OP_SUB, 32'd50, 32'd8);
    #1;
    for (int i = 0; i < 20 && !bus.rsp0_valid; i++) begin
      @(negedge clk); #1;
    end
    check("bp_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd1);
    held = bus.rsp0_data;
    check("bp_data", {32'd0, held}, 64'd123);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("bp_data_stable", {32'd0, bus.rsp0_data}, 64'd123);
      check("bp_busy", {63'd0, bus.busy}, 64'd1);
      check("bp_req1_ready", {63'd0, bus.req1_ready}, 64'd0);
      check("bp_rsp0_valid_hold", {63'd0, bus.rsp0_valid}, 64'd1);
    end
    @(negedge clk);
    bus.rsp0_ready = 1'b1;
    @(negedge clk); #1;
    check("bp_idle", {63'd0, bus.busy}, 64'd0);
    check("bp_req1_granted", {63'd0, bus.req1_ready}, 64'd1);
    push(1'b1, 32'd42, 1'b0);
    @(negedge clk);
    set_req(1'b1, 1'b0, OP_SUB, 32'd50, 32'd8);
    wait_idle();

    // Reset during EXEC drops the op and restores prio to 0
    @(negedge clk);
    set_req(1'b0, 1'b1, OP_ADD, 32'd1, 32'd1);
    #1;
    check("mid_ready0", {63'd0, bus.req0_ready}, 64'd1);
    @(negedge clk);
    set_req(1'b1, 1'b1, OP_SUB, 32'd7, 32'd2);
    #1;
    check("mid_in_exec", {63'd0, bus.busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy", {63'd0, bus.busy}, 64'd0);
    check("mid_ready0_rst", {63'd0, bus.req0_ready}, 64'd0);
    check("mid_ready1_rst", {63'd0, bus.req1_ready}, 64'd0);
    check("mid_rsp0_valid", {63'd0, bus.rsp0_valid}, 64'd0);
    check("mid_alu_left", {32'd0, bus.alu_left}, 64'd0);
    check("mid_alu_right", {32'd0, bus.alu_right}, 64'd0);
    @(negedge clk);
    set_req(1'b0, 1'b0, OP_SUB, 32'd7, 32'd2);
    set_req(1'b1, 1'b0, OP_SUB, 32'd7, 32'd2);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus.rsp0_valid || bus.rsp1_valid) seen = 1'b1;
    end
    check("mid_no_rsp", {63'd0, seen}, 64'd0);
    @(negedge clk);
    set_req(1'b0, 1'b1, OP_SUB, 32'd7, 32'd2);
    set_req(1'b1, 1'b1, OP_SUB, 32'd7, 32'd2);
    #1;
    check("mid_prio_ready0", {63'd0, bus.req0_ready}, 64'd1);
    check("mid_prio_ready1", {63'd0, bus.req1_ready}, 64'd0);
    push(1'b0, 32'd5, 1'b1);
    @(negedge clk);
    set_req(1'b0, 1'b0, OP_SUB, 32'd7, 32'd2);
    set_req(1'b1, 1'b0, OP_SUB, 32'd7, 32'd2);
    wait_idle();

    // Table of single-port ops; ends with port 1 twice
    for (int k = 0; k < 7; k++) issue(vecs[k]);
    check("held_alu_op", {59'd0, bus.alu_op}, {59'd0, OP_SUB});
    check("held_alu_right", {32'd0, bus.alu_right}, 64'd1);

    // After port 1 twice, a tie goes to port 0
    @(negedge clk);
    set_req(1'b0, 1'b1, OP_ADD, 32'd1, 32'd2);
    set_req(1'b1, 1'b1, OP_SUB, 32'd1, 32'd1);
    #1;
    check("prio_ready0", {63'd0, bus.req0_ready}, 64'd1);
    check("prio_ready1", {63'd0, bus.req1_ready}, 64'd0);
    push(1'b0, 32'd3, 1'b1);
    @(negedge clk);
    set_req(1'b0, 1'b0, OP_ADD, 32'd1, 32'd2);
    #1;
    for (int i = 0; i < 20 && !bus.req1_ready; i++) begin
      @(negedge clk); #1;
    end
    check("prio_then_ready1", {63'd0, bus.req1_ready}, 64'd1);
    push(1'b1, 32'd0, 1'b0);
    @(negedge clk);
    set_req(1'b1, 1'b0, OP_SUB, 32'd1, 32'd1);
    wait_idle();

    repeat (3) @(negedge clk);
    #3;
    check("sb_empty", sb.size(), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
